// File: rtl/rf_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_stage
// Brief    : Merges ALU results and load returns onto the single RF write
//            port, buffering same-cycle collisions in an in-order queue.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_stage #(
    parameter int DW    = 16,
    parameter int AW    = 4,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_vld,
    input  logic [AW-1:0]       alu_dst_addr,
    input  logic [DW-1:0]       alu_data,
    input  logic                ld_vld,
    input  logic [AW-1:0]       ld_dst_addr,
    input  logic [DW-1:0]       ld_data,
    output logic                we,
    output logic [AW-1:0]       dst_addr,
    output logic [DW-1:0]       dst,
    output logic                stall,
    output logic [(2**AW)-1:0]  pend_mask,
    output logic                ovf_err
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_NR = 2 ** AW;
    localparam logic [c_CW:0] c_DEPTH_X = (c_CW + 1)'(DEPTH);

    logic [AW-1:0]   r_q_addr [DEPTH];
    logic [DW-1:0]   r_q_data [DEPTH];
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_we;
    logic [AW-1:0]   r_dst_addr;
    logic [DW-1:0]   r_dst;
    logic [c_NR-1:0] r_pend;
    logic            r_ovf;

    logic            w_ld_ok, w_alu_ok, w_q_has, w_deq, w_ovf;
    logic            w_hd_vld;
    logic [AW-1:0]   w_hd_addr, w_e0_addr, w_e1_addr;
    logic [DW-1:0]   w_hd_data, w_e0_data, w_e1_data;
    logic [1:0]      w_n_new, w_n_acc;
    logic [c_CW:0]   w_free, w_count_nxt;
    logic [c_PW-1:0] w_rd_nxt, w_wr1, w_wr_nxt;
    logic [AW-1:0]   w_na [DEPTH];
    logic [DW-1:0]   w_nd [DEPTH];
    logic [c_NR-1:0] w_pend_nxt;

    function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
        f_inc = (p == c_PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Head selection: queue head is oldest, then the load, then the ALU result.
    always_comb begin
        w_ld_ok   = ld_vld && (ld_dst_addr != '0);
        w_alu_ok  = alu_vld && (alu_dst_addr != '0);
        w_q_has   = (r_count != '0);
        w_hd_vld  = 1'b0;
        w_hd_addr = r_q_addr[r_rd_ptr];
        w_hd_data = r_q_data[r_rd_ptr];
        w_e0_addr = alu_dst_addr;
        w_e0_data = alu_data;
        w_e1_addr = alu_dst_addr;
        w_e1_data = alu_data;
        w_n_new   = 2'd0;
        if (w_q_has) begin
            w_hd_vld = 1'b1;
            if (w_ld_ok) begin
                w_e0_addr = ld_dst_addr;
                w_e0_data = ld_data;
                w_n_new   = w_alu_ok ? 2'd2 : 2'd1;
            end else if (w_alu_ok) begin
                w_n_new = 2'd1;
            end
        end else if (w_ld_ok) begin
            w_hd_vld  = 1'b1;
            w_hd_addr = ld_dst_addr;
            w_hd_data = ld_data;
            w_n_new   = w_alu_ok ? 2'd1 : 2'd0;
        end else if (w_alu_ok) begin
            w_hd_vld  = 1'b1;
            w_hd_addr = alu_dst_addr;
            w_hd_data = alu_data;
        end
    end

    // Slot accounting; on shortage the newest candidate (ALU) is dropped.
    always_comb begin
        w_deq  = w_q_has;
        w_free = c_DEPTH_X - {1'b0, r_count} + {{c_CW{1'b0}}, w_deq};
        if ({{(c_CW - 1){1'b0}}, w_n_new} > w_free) begin
            w_n_acc = w_free[1:0];
            w_ovf   = 1'b1;
        end else begin
            w_n_acc = w_n_new;
            w_ovf   = 1'b0;
        end
        w_count_nxt = {1'b0, r_count} + {{(c_CW - 1){1'b0}}, w_n_acc}
                    - {{c_CW{1'b0}}, w_deq};
        w_rd_nxt = w_deq ? f_inc(r_rd_ptr) : r_rd_ptr;
        w_wr1    = f_inc(r_wr_ptr);
        case (w_n_acc)
            2'd0:    w_wr_nxt = r_wr_ptr;
            2'd1:    w_wr_nxt = w_wr1;
            default: w_wr_nxt = f_inc(w_wr1);
        endcase
    end

    // Post-edge queue image, used both for storage update and the pending mask.
    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_na[i] = r_q_addr[i];
            w_nd[i] = r_q_data[i];
            if ((w_n_acc != 2'd0) && (r_wr_ptr == c_PW'(i))) begin
                w_na[i] = w_e0_addr;
                w_nd[i] = w_e0_data;
            end
            if ((w_n_acc == 2'd2) && (w_wr1 == c_PW'(i))) begin
                w_na[i] = w_e1_addr;
                w_nd[i] = w_e1_data;
            end
            if (((i - int'(w_rd_nxt) + DEPTH) % DEPTH) < int'(w_count_nxt))
                w_pend_nxt[w_na[i]] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q_addr   <= '{default: '0};
            r_q_data   <= '{default: '0};
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_we       <= 1'b0;
            r_dst_addr <= '0;
            r_dst      <= '0;
            r_pend     <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_q_addr <= w_na;
            r_q_data <= w_nd;
            r_rd_ptr <= w_rd_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_count  <= w_count_nxt[c_CW-1:0];
            r_we     <= w_hd_vld;
            if (w_hd_vld) begin
                r_dst_addr <= w_hd_addr;
                r_dst      <= w_hd_data;
            end
            r_pend <= w_pend_nxt;
            if (w_ovf)
                r_ovf <= 1'b1;
        end
    end

    assign we        = r_we;
    assign dst_addr  = r_dst_addr;
    assign dst       = r_dst;
    assign pend_mask = r_pend;
    assign ovf_err   = r_ovf;
    assign stall     = ((c_DEPTH_X - {1'b0, r_count}) < (c_CW + 1)'(2));

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_stage
// Brief    : Self-checking bench for rf_wb_stage against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_stage;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int VW    = 1 + AW + DW + 1 + (2**AW) + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               alu_vld = 1'b0;
    logic [AW-1:0]      alu_dst_addr = '0;
    logic [DW-1:0]      alu_data = '0;
    logic               ld_vld = 1'b0;
    logic [AW-1:0]      ld_dst_addr = '0;
    logic [DW-1:0]      ld_data = '0;
    logic               we;
    logic [AW-1:0]      dst_addr;
    logic [DW-1:0]      dst;
    logic               stall;
    logic [(2**AW)-1:0] pend_mask;
    logic               ovf_err;

    rf_wb_stage #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_vld(alu_vld), .alu_dst_addr(alu_dst_addr), .alu_data(alu_data),
        .ld_vld(ld_vld), .ld_dst_addr(ld_dst_addr), .ld_data(ld_data),
        .we(we), .dst_addr(dst_addr), .dst(dst), .stall(stall),
        .pend_mask(pend_mask), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } item_t;

    item_t         mq[$];
    logic          exp_we   = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_dst  = '0;
    logic          exp_ovf  = 1'b0;
    int            n_chk    = 0;
    int            n_fail   = 0;
    logic [VW-1:0] obs, expv;

    // Program order is queue, then load, then ALU; the oldest goes out,
    // the rest stay queued and anything beyond DEPTH (newest first) is lost.
    task automatic model_step(input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                              input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
        item_t all[$];
        item_t h;
        all = mq;
        if (lv && la != 0) all.push_back('{la, ldd});
        if (av && aa != 0) all.push_back('{aa, ad});
        if (all.size() > 0) begin
            h = all.pop_front();
            exp_we = 1'b1; exp_addr = h.a; exp_dst = h.d;
        end else begin
            exp_we = 1'b0;
        end
        while (all.size() > DEPTH) begin
            void'(all.pop_back());
            exp_ovf = 1'b1;
        end
        mq = all;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [(2**AW)-1:0] pm;
        logic st;
        pm = '0;
        foreach (mq[k]) pm[mq[k].a] = 1'b1;
        st = (DEPTH - mq.size()) < 2;
        return {exp_we, exp_addr, exp_dst, st, pm, exp_ovf};
    endfunction

    task automatic cycle(input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                         input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
        ld_vld = lv; ld_dst_addr = la; ld_data = ldd;
        alu_vld = av; alu_dst_addr = aa; alu_data = ad;
        @(posedge clk);
        model_step(lv, la, ldd, av, aa, ad);
        #1;
        ld_vld = 1'b0; alu_vld = 1'b0;
        obs  = {we, dst_addr, dst, stall, pend_mask, ovf_err};
        expv = exp_vec();
    endtask

    task automatic test_reset();
        #1;
        obs = {we, dst_addr, dst, stall, pend_mask, ovf_err};
        n_chk++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, {VW{1'b0}});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_alu();
        cycle(0, 0, 0, 1, 4'd3, 16'h1234);
        n_chk++;
        if (we !== 1'b1 || dst_addr !== 4'd3 || dst !== 16'h1234) begin
            n_fail++;
            $display("FAIL alu_latency: got we=%b addr=%h dst=%h expected we=1 addr=3 dst=1234", we, dst_addr, dst);
        end
        cycle(0, 0, 0, 0, 0, 0);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL alu_idle: got %h expected %h", obs, expv);
        end
    endtask

    task automatic test_dual();
        cycle(1, 4'd5, 16'hAAAA, 1, 4'd6, 16'h5555);
        n_chk++;
        if (obs !== expv || pend_mask !== 16'h0040) begin
            n_fail++;
            $display("FAIL dual_c1: got %h expected %h pend=%h", obs, expv, pend_mask);
        end
        cycle(0, 0, 0, 0, 0, 0);
        n_chk++;
        if (obs !== expv || dst !== 16'h5555 || pend_mask !== 16'h0000) begin
            n_fail++;
            $display("FAIL dual_c2: got %h expected %h", obs, expv);
        end
    endtask

    task automatic test_waw();
        cycle(1, 4'd7, 16'h1111, 1, 4'd7, 16'h2222);
        n_chk++;
        if (obs !== expv || dst !== 16'h1111) begin
            n_fail++;
            $display("FAIL waw_first: got %h expected %h", obs, expv);
        end
        cycle(0, 0, 0, 0, 0, 0);
        n_chk++;
        if (obs !== expv || dst !== 16'h2222 || we !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_second: got %h expected %h", obs, expv);
        end
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_r0();
        for (int k = 0; k < 3; k++) begin
            cycle(k != 0, 4'd0, 16'hBEEF, k != 1, 4'd0, 16'hCAFE);
            n_chk++;
            if (obs !== expv || we !== 1'b0 || pend_mask !== '0 || stall !== 1'b0) begin
                n_fail++;
                $display("FAIL r0_filter[%0d]: got %h expected %h", k, obs, expv);
            end
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 3; k++) begin
            cycle(1, 4'(2 + 2*k), 16'(16'h100 + k), 1, 4'(3 + 2*k), 16'(16'h200 + k));
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL fill[%0d]: got %h expected %h", k, obs, expv);
            end
        end
        n_chk++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_at_3: got %b expected 1", stall);
        end
        for (int k = 0; k < 2; k++) begin
            cycle(1, 4'(9 + k), 16'(16'h300 + k), 0, 0, 0);
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL ld_only[%0d]: got %h expected %h", k, obs, expv);
            end
        end
        cycle(1, 4'd11, 16'h0400, 1, 4'd12, 16'h0401);
        n_chk++;
        if (obs !== expv || ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_to_4: got %h expected %h", obs, expv);
        end
        cycle(1, 4'd13, 16'h0500, 1, 4'd14, 16'h0501);
        n_chk++;
        if (obs !== expv || ovf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: got %h expected %h", obs, expv);
        end
        cycle(0, 0, 0, 0, 0, 0);
        n_chk++;
        if (obs !== expv || ovf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %h expected %h", obs, expv);
        end
    endtask

    task automatic test_reset_mid();
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (we !== 1'b0 || stall !== 1'b0 || pend_mask !== '0 || ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got we=%b stall=%b pend=%h ovf=%b expected all 0",
                     we, stall, pend_mask, ovf_err);
        end
        mq.delete();
        exp_we = 1'b0; exp_addr = '0; exp_dst = '0; exp_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0, 0, 0);
            n_chk++;
            if (obs !== expv || we !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got %h expected %h", k, obs, expv);
            end
        end
    endtask

    task automatic test_random();
        bit lv, av;
        for (int k = 0; k < 300; k++) begin
            lv = ($urandom_range(0, 99) < 60);
            av = ($urandom_range(0, 99) < 70) && !((DEPTH - mq.size()) < 2);
            cycle(lv, 4'($urandom_range(0, 15)), 16'($urandom),
                  av, 4'($urandom_range(0, 15)), 16'($urandom));
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", k, obs, expv);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_single_alu();
        test_dual();
        test_waw();
        test_r0();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
